decode_skid_stage: RTL and testbench
====================================

DECODE_SKID_STAGE -- requirements
Module: decode_skid_stage

Interface
REQ-001 Parameter N, default 32, is the datapath width of the instruction and PC.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; asserting it (0) clears state immediately, independent of clk.
REQ-004 flush  input  1  synchronous kill of all buffered instructions (branch/jump redirect).
REQ-005 in_valid  input  1  fetch presents an instruction.
REQ-006 in_ready  output  1  stage accepts the instruction this cycle.
REQ-007 in_instr  input  N  fetched instruction word.
REQ-008 in_pc  input  N  PC of in_instr.
REQ-009 out_valid  output  1  decoded entry available to the execute stage.
REQ-010 out_ready  input  1  execute consumes the head entry this cycle.
REQ-011 out_instr  output  N  head instruction, passed unchanged to the immediate generator.
REQ-012 out_pc  output  N  PC of the head instruction.
REQ-013 out_imm_sel  output  2  immediate format: 0=I, 1=S, 2=B, 3=U.
REQ-014 out_is_jal  output  1  head is JAL; J-format immediate is built outside the 4-way immediate mux.
REQ-015 out_illegal  output  1  head opcode is not in the supported set.

Function
REQ-016 The stage SHALL be a 2-entry in-order buffer with states EMPTY, ONE, TWO (entry count 0/1/2).
REQ-017 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-018 in_ready SHALL be a registered output equal to 1 in EMPTY and ONE and 0 in TWO; it is never combinationally dependent on out_ready.
REQ-019 out_valid SHALL be 1 exactly in ONE and TWO; out_* fields SHALL always reflect the oldest entry.
REQ-020 Transitions: EMPTY+in -> ONE; ONE+in, no out -> TWO; ONE+out, no in -> EMPTY; ONE+in+out -> ONE (new entry becomes head, next cycle); TWO+out -> ONE (second entry promoted to head); all other cases hold state.
REQ-021 Latency: an instruction accepted on edge k SHALL appear at out_* in the cycle after edge k when the buffer was EMPTY; there is no combinational path from in_* to out_*.
REQ-022 Decode SHALL be computed from in_instr[6:0] at accept time and stored with the entry.
REQ-023 Opcode map: 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR, 1110011 SYSTEM -> imm_sel 0; 0100011 STORE -> 1; 1100011 BRANCH -> 2; 0110111 LUI, 0010111 AUIPC -> 3; 0110011 OP -> imm_sel 0, legal; 1101111 JAL -> imm_sel 3, is_jal 1.
REQ-024 Any other opcode (including instr[1:0] != 2'b11) SHALL set illegal 1, imm_sel 0, is_jal 0.
REQ-025 flush SHALL, on the next edge, force EMPTY, out_valid 0, in_ready 1; an input offered in the flush cycle SHALL be dropped, and flush has priority over every simultaneous transfer.
REQ-026 out_ready while EMPTY and in_valid while TWO SHALL have no effect.
REQ-027 PC and instruction SHALL be stored bit-exact; no arithmetic on PC.

Reset
REQ-028 While rst is 0: state EMPTY, out_valid 0, in_ready 0; out_instr, out_pc 0; out_imm_sel 0; out_is_jal 0; out_illegal 0.
REQ-029 On the first rising edge after rst rises, in_ready SHALL become 1; reset asserted mid-transfer SHALL discard all entries with no partial update.

Verification
REQ-030 Reset then in_instr=0x00A00093 (addi), pc=0x0, out_ready=1 -> next cycle out_valid 1, out_imm_sel 0, out_illegal 0, out_pc 0x0.
REQ-031 out_ready=0; push 0x00112023 (sw) then 0xFE000EE3 (beq) -> in_ready 0 after second push; out_imm_sel 1 then, after one out_ready pulse, 2 with out_pc of the beq.
REQ-032 TWO state with flush=1 and in_valid=1 -> next cycle out_valid 0, in_ready 1; offered instruction never appears at out_*.
REQ-033 Push 0x000012B7 (lui) and 0x0000006F (jal) back-to-back with out_ready=1 -> imm_sel 3/is_jal 0, then imm_sel 3/is_jal 1, one per cycle, no bubble.
REQ-034 Push 0xFFFFFFFF -> out_illegal 1, out_imm_sel 0; assert rst low while in TWO -> out_valid 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/decode_skid_stage.sv
// Two-entry in-order skid buffer between fetch and execute that pre-decodes the opcode.
// Decode results are captured alongside each entry, so out_* always come straight from registers.
module decode_skid_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_instr,
  input  logic [N-1:0] in_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_instr,
  output logic [N-1:0] out_pc,
  output logic [1:0]   out_imm_sel,
  output logic         out_is_jal,
  output logic         out_illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic       illegal;
    logic       is_jal;
    logic [1:0] imm_sel;
  } dec_t;

  // JAL reports imm_sel U but is flagged separately; its J immediate is built outside the mux.
  function automatic dec_t decode_op(input logic [6:0] op);
    dec_t d;
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b1110011, 7'b0110011:              d = '{illegal: 1'b0, is_jal: 1'b0, imm_sel: 2'd0};
      7'b0100011:                          d = '{illegal: 1'b0, is_jal: 1'b0, imm_sel: 2'd1};
      7'b1100011:                          d = '{illegal: 1'b0, is_jal: 1'b0, imm_sel: 2'd2};
      7'b0110111, 7'b0010111:              d = '{illegal: 1'b0, is_jal: 1'b0, imm_sel: 2'd3};
      7'b1101111:                          d = '{illegal: 1'b0, is_jal: 1'b1, imm_sel: 2'd3};
      default:                             d = '{illegal: 1'b1, is_jal: 1'b0, imm_sel: 2'd0};
    endcase
    return d;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [N-1:0] head_instr_r;
  logic [N-1:0] head_pc_r;
  dec_t         head_dec_r;
  logic [N-1:0] tail_instr_r;
  logic [N-1:0] tail_pc_r;
  dec_t         tail_dec_r;

  logic push_s;
  logic pop_s;
  logic head_from_in_s;
  logic head_from_tail_s;
  logic tail_from_in_s;
  dec_t in_dec_s;

  assign push_s   = in_valid && in_ready_r;
  assign pop_s    = out_valid_r && out_ready;
  assign in_dec_s = decode_op(in_instr[6:0]);

  // Next-state and entry-load selection; flush overrides every transfer.
  always_comb begin
    state_nxt_s      = state_r;
    head_from_in_s   = 1'b0;
    head_from_tail_s = 1'b0;
    tail_from_in_s   = 1'b0;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            state_nxt_s    = ONE;
            head_from_in_s = 1'b1;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            state_nxt_s    = ONE;
            head_from_in_s = 1'b1;
          end else if (push_s) begin
            state_nxt_s    = TWO;
            tail_from_in_s = 1'b1;
          end else if (pop_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
        end
        TWO: begin
          if (pop_s) begin
            state_nxt_s      = ONE;
            head_from_tail_s = 1'b1;
          end else begin
            state_nxt_s = TWO;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  // State, handshake flags and entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= EMPTY;
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      head_instr_r <= '0;
      head_pc_r    <= '0;
      head_dec_r   <= '0;
      tail_instr_r <= '0;
      tail_pc_r    <= '0;
      tail_dec_r   <= '0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != TWO);
      out_valid_r <= (state_nxt_s != EMPTY);
      if (head_from_in_s) begin
        head_instr_r <= in_instr;
        head_pc_r    <= in_pc;
        head_dec_r   <= in_dec_s;
      end else if (head_from_tail_s) begin
        head_instr_r <= tail_instr_r;
        head_pc_r    <= tail_pc_r;
        head_dec_r   <= tail_dec_r;
      end else begin
        head_instr_r <= head_instr_r;
        head_pc_r    <= head_pc_r;
        head_dec_r   <= head_dec_r;
      end
      if (tail_from_in_s) begin
        tail_instr_r <= in_instr;
        tail_pc_r    <= in_pc;
        tail_dec_r   <= in_dec_s;
      end else begin
        tail_instr_r <= tail_instr_r;
        tail_pc_r    <= tail_pc_r;
        tail_dec_r   <= tail_dec_r;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_instr   = head_instr_r;
  assign out_pc      = head_pc_r;
  assign out_imm_sel = head_dec_r.imm_sel;
  assign out_is_jal  = head_dec_r.is_jal;
  assign out_illegal = head_dec_r.illegal;

endmodule

// File: tb/tb_decode_skid_stage.sv
// Directed bench for decode_skid_stage with hand-computed expectations.
module tb_decode_skid_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  out_imm_sel;
  logic        out_is_jal;
  logic        out_illegal;

  int checks;
  int errors;

  decode_skid_stage #(.N(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_imm_sel(out_imm_sel), .out_is_jal(out_is_jal), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [31:0] pc,
                            input logic [1:0] sel, input logic jal, input logic ill);
    check_eq({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check_eq({tag, ".pc"}, out_pc, pc);
    check_eq({tag, ".imm_sel"}, {30'd0, out_imm_sel}, {30'd0, sel});
    check_eq({tag, ".is_jal"}, {31'd0, out_is_jal}, {31'd0, jal});
    check_eq({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, ill});
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  sel;
    logic        jal;
    logic        ill;
  } vec_t;

  vec_t vecs[12];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 32'd0;

    vecs[0]  = '{32'hA5A5A503, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{32'hA5A5A523, 2'd1, 1'b0, 1'b0};
    vecs[2]  = '{32'hA5A5A563, 2'd2, 1'b0, 1'b0};
    vecs[3]  = '{32'hA5A5A567, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{32'hA5A5A56F, 2'd3, 1'b1, 1'b0};
    vecs[5]  = '{32'hA5A5A573, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{32'hA5A5A537, 2'd3, 1'b0, 1'b0};
    vecs[7]  = '{32'hA5A5A517, 2'd3, 1'b0, 1'b0};
    vecs[8]  = '{32'hA5A5A533, 2'd0, 1'b0, 1'b0};
    vecs[9]  = '{32'hA5A5A513, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{32'hA5A5A57F, 2'd0, 1'b0, 1'b1};
    vecs[11] = '{32'hA5A5A512, 2'd0, 1'b0, 1'b1};

    // Reset values while rst is held low.
    #3 rst = 1'b0;
    #1;
    check_eq("rst.in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst.instr", out_instr, 32'd0);
    check_head("rst", 1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    check_eq("rst_hold.in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check_eq("post_rst.in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("post_rst.valid", {31'd0, out_valid}, 32'd0);

    // addi with out_ready high: one-cycle latency from EMPTY.
    in_valid = 1'b1; in_instr = 32'h00A00093; in_pc = 32'h0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_head("addi", 1'b1, 32'h0, 2'd0, 1'b0, 1'b0);
    check_eq("addi.instr", out_instr, 32'h00A00093);
    step();
    check_eq("addi.drain", {31'd0, out_valid}, 32'd0);

    // sw then beq with out_ready low fills the buffer.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00112023; in_pc = 32'h100;
    step();
    check_head("sw", 1'b1, 32'h100, 2'd1, 1'b0, 1'b0);
    check_eq("sw.in_ready", {31'd0, in_ready}, 32'd1);
    in_instr = 32'hFE000EE3; in_pc = 32'h104;
    step();
    check_eq("two.in_ready", {31'd0, in_ready}, 32'd0);
    check_head("two.head", 1'b1, 32'h100, 2'd1, 1'b0, 1'b0);
    // Input offered while full is ignored.
    in_instr = 32'h000012B7; in_pc = 32'h999;
    step();
    in_valid = 1'b0;
    check_head("two.hold", 1'b1, 32'h100, 2'd1, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_head("beq", 1'b1, 32'h104, 2'd2, 1'b0, 1'b0);
    check_eq("beq.instr", out_instr, 32'hFE000EE3);
    check_eq("beq.in_ready", {31'd0, in_ready}, 32'd1);

    // Refill to TWO, then flush with a simultaneous offer.
    in_valid = 1'b1; in_instr = 32'h00A00093; in_pc = 32'h200;
    step();
    check_eq("refill.in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; in_instr = 32'h0000006F; in_pc = 32'h300;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush.valid", {31'd0, out_valid}, 32'd0);
    check_eq("flush.in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    check_eq("flush.dropped", {31'd0, out_valid}, 32'd0);
    check_eq("flush.in_ready2", {31'd0, in_ready}, 32'd1);

    // lui then jal back-to-back, no bubble.
    in_valid = 1'b1; in_instr = 32'h000012B7; in_pc = 32'h400;
    step();
    check_head("lui", 1'b1, 32'h400, 2'd3, 1'b0, 1'b0);
    in_instr = 32'h0000006F; in_pc = 32'h404;
    step();
    check_head("jal", 1'b1, 32'h404, 2'd3, 1'b1, 1'b0);
    check_eq("jal.in_ready", {31'd0, in_ready}, 32'd1);

    // Opcode table streamed with out_ready high.
    for (int i = 0; i < 12; i++) begin
      in_instr = vecs[i].instr;
      in_pc = 32'h1000 + 32'(i) * 32'd4;
      step();
      check_head($sformatf("op%0d", i), 1'b1, 32'h1000 + 32'(i) * 32'd4,
                 vecs[i].sel, vecs[i].jal, vecs[i].ill);
      check_eq($sformatf("op%0d.instr", i), out_instr, vecs[i].instr);
    end
    in_valid = 1'b0;
    step();
    check_eq("table.drain", {31'd0, out_valid}, 32'd0);

    // All-ones word is illegal; then async reset while full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h500;
    step();
    check_head("ones", 1'b1, 32'h500, 2'd0, 1'b0, 1'b1);
    in_instr = 32'h00000010; in_pc = 32'h504;
    step();
    in_valid = 1'b0;
    check_eq("full.in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check_eq("async.valid", {31'd0, out_valid}, 32'd0);
    check_eq("async.in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("async.pc", out_pc, 32'd0);
    check_eq("async.illegal", {31'd0, out_illegal}, 32'd0);
    step();
    rst = 1'b1;
    step();
    check_eq("rerst.in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rerst.valid", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
